// File: rtl/reg_dump_if.sv
// Output beat stream of the register dumper: valid/ready handshake carrying
// one register value (or the trailer checksum) with its index and last flag.
interface reg_dump_if #(
   parameter int pw = 4
);
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic [pw-1:0] out_index;
   logic          out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/reg_dump.sv
// Walks all 2**pw registers through a combinational read port, streams each
// byte out, then sends a trailer beat with the modulo-256 sum of the values.
module reg_dump #(
   parameter int pw = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [pw:0]   rd_addr,
   input  logic [7:0]    rd_data,
   output logic          busy,
   output logic          done,
   reg_dump_if.master    out_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SEND  = 2'd2,
      TRAIL = 2'd3
   } state_t;

   localparam logic [pw-1:0] LAST_IDX = '1;

   state_t        state_q, state_d;
   logic [pw:0]   rd_addr_q, rd_addr_d;
   logic [pw-1:0] index_q, index_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    out_data_q, out_data_d;
   logic [pw-1:0] out_index_q, out_index_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          accept;
   logic [7:0]    sum_acc;

   assign accept  = out_valid_q && out_if.out_ready;
   assign sum_acc = sum_q + out_data_q;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      index_d     = index_q;
      sum_d       = sum_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               rd_addr_d = '0;
               index_d   = '0;
               sum_d     = '0;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            out_index_d = index_q;
            out_last_d  = 1'b0;
            state_d     = SEND;
         end
         SEND: begin
            if (accept) begin
               sum_d = sum_acc;
               if (index_q != LAST_IDX) begin
                  index_d     = index_q + pw'(1);
                  rd_addr_d   = rd_addr_q + (pw+1)'(1);
                  out_valid_d = 1'b0;
                  state_d     = LOAD;
               end else begin
                  // Trailer goes out back-to-back: valid stays high, no LOAD bubble.
                  out_data_d  = sum_acc;
                  out_index_d = '1;
                  out_last_d  = 1'b1;
                  state_d     = TRAIL;
               end
            end
         end
         TRAIL: begin
            if (accept) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         index_q     <= '0;
         sum_q       <= '0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         index_q     <= index_d;
         sum_q       <= sum_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr          = rd_addr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_data_q;
   assign out_if.out_index = out_index_q;
   assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump.sv
// Randomized bench for reg_dump: stimulus pushes the expected beat stream of
// each dump into a queue, a negedge monitor pops and compares accepted beats.
module tb_reg_dump;

   localparam int PW   = 4;
   localparam int NREG = 1 << PW;

   typedef struct {
      logic [7:0]    data;
      logic [PW-1:0] idx;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [PW:0]   rd_addr;
   logic [7:0]    rd_data;
   logic          busy;
   logic          done;
   logic [7:0]    regs [NREG];

   reg_dump_if #(.pw(PW)) out_if ();

   reg_dump #(.pw(PW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .out_if  (out_if)
   );

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr[PW-1:0]];

   int    n_checks = 0;
   int    n_pass   = 0;
   beat_t exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: beats are the register contents in order, trailer is their sum mod 256.
   task automatic push_dump();
      int    total;
      beat_t b;
      total = 0;
      for (int i = 0; i < NREG; i++) begin
         b.data = regs[i];
         b.idx  = PW'(i);
         b.last = 1'b0;
         exp_q.push_back(b);
         total += int'(regs[i]);
      end
      b.data = 8'(total % 256);
      b.idx  = '1;
      b.last = 1'b1;
      exp_q.push_back(b);
   endtask

   // Monitor: compares accepted beats and checks beats stay stable while stalled.
   beat_t held;
   bit    held_v   = 0;
   bit    done_exp = 0;

   always @(negedge clk) begin
      beat_t got;
      beat_t e;
      if (!rst_n) begin
         held_v   = 0;
         done_exp = 0;
      end else begin
         if (done || done_exp) chk("done_pulse", done, done_exp);
         done_exp = 0;
         if (out_if.out_valid) begin
            got.data = out_if.out_data;
            got.idx  = out_if.out_index;
            got.last = out_if.out_last;
            if (held_v) begin
               chk("stall_data", got.data, held.data);
               chk("stall_index", got.idx, held.idx);
               chk("stall_last", got.last, held.last);
            end
            if (out_if.out_ready) begin
               held_v = 0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat_idx", got.idx, ~got.idx);
               end else begin
                  e = exp_q.pop_front();
                  $display("beat idx=%0h data=%02h last=%0b (exp %0h/%02h/%0b)",
                           got.idx, got.data, got.last, e.idx, e.data, e.last);
                  chk("beat_data", got.data, e.data);
                  chk("beat_index", got.idx, e.idx);
                  chk("beat_last", got.last, e.last);
                  if (e.last) done_exp = 1;
               end
            end else begin
               held_v = 1;
               held   = got;
            end
         end else begin
            held_v = 0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_valid"}, out_if.out_valid, 0);
      chk({tag, "_data"}, out_if.out_data, 0);
      chk({tag, "_index"}, out_if.out_index, 0);
      chk({tag, "_last"}, out_if.out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // Runs one dump from the current posedge+1 point; returns cycles until done is seen.
   task automatic run_dump(input bit rand_ready, input bit hold_start, input int wr_beat,
                           output int cyc);
      bit wrote;
      wrote = 0;
      cyc   = 0;
      start = 1'b1;
      while (cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            chk("start_busy", busy, 1);
            chk("start_rd_addr", rd_addr, 0);
         end
         if (!hold_start) start = 1'b0;
         if (wr_beat >= 0 && !wrote && out_if.out_valid &&
             out_if.out_index == wr_beat[PW-1:0] && !out_if.out_last) begin
            regs[12] = 8'h55;
            wrote    = 1;
         end
         if (done) break;
         out_if.out_ready = rand_ready ? 1'($urandom) : 1'b1;
      end
      chk("done_seen", done, 1);
      chk("rd_addr_hold", rd_addr, NREG - 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      out_if.out_ready = 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] = 8'h00;
      #2 rst_n = 1'b0;
      idle(3);
      check_reset_outputs("por");
      rst_n = 1'b1;
      idle(3);
      chk("idle_busy", busy, 0);

      // Ascending pattern, sink always ready: fixed 34-cycle dump.
      for (int i = 0; i < NREG; i++) regs[i] = 8'(8'h10 + i);
      push_dump();
      run_dump(0, 0, -1, cyc);
      chk("dump_cycles_ramp", cyc, 34);
      idle(2);

      // All ones: checksum must wrap modulo 256.
      for (int i = 0; i < NREG; i++) regs[i] = 8'hFF;
      push_dump();
      run_dump(0, 0, -1, cyc);
      chk("dump_cycles_ff", cyc, 34);
      idle(2);

      // Random data with random backpressure.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
         push_dump();
         run_dump(1, 0, -1, cyc);
         idle(1 + r);
      end

      // Start held through a dump: one dump, then a new one from the done cycle.
      for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
      push_dump();
      push_dump();
      run_dump(0, 1, -1, cyc);
      chk("held_start_cycles1", cyc, 34);
      run_dump(0, 0, -1, cyc);
      chk("held_start_cycles2", cyc, 34);
      idle(2);

      // Reset asserted while beat 7 is pending.
      for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
      push_dump();
      start = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (out_if.out_valid && out_if.out_index == 4'd7 && !out_if.out_last) break;
         out_if.out_ready = 1'($urandom);
      end
      chk("beat7_reached", out_if.out_index, 7);
      out_if.out_ready = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("midrst");
      idle(2);
      rst_n = 1'b1;
      out_if.out_ready = 1'b1;
      idle(5);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", out_if.out_valid, 0);
      chk("post_rst_rd_addr", rd_addr, 0);
      push_dump();
      run_dump(1, 0, -1, cyc);
      idle(2);

      // Register 12 rewritten mid-dump: the new value must appear.
      for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
      regs[12] = 8'h55;
      push_dump();
      regs[12] = 8'h00;
      run_dump(0, 0, 3, cyc);
      chk("reg12_written", regs[12], 8'h55);
      idle(5);

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
